// File: rtl/slice_mem_arbiter_if.sv
// Requester-side bus of the slice state memory arbiter: per-requester requests,
// strobes and flattened address/data in, one-hot grant and read return out.
interface slice_mem_arbiter_if #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 25
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        last;
    logic [NUM_REQ-1:0]        re;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;
    logic [NUM_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic                      err;

    modport master (
        output req, last, re, we, addr, wdata,
        input  grant, busy, rd_valid, rd_data, err
    );

    modport slave (
        input  req, last, re, we, addr, wdata,
        output grant, busy, rd_valid, rd_data, err
    );
endinterface

// File: rtl/slice_mem_arbiter.sv
// Round-robin, burst-locked arbiter sharing the single-port slice memory between host and stage engines.
// Optional watchdog on burst length is built when ARB_WATCHDOG_EN is defined.
module slice_mem_arbiter #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 25
`ifdef ARB_WATCHDOG_EN
    ,
    parameter int unsigned MAX_BURST = 128
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    slice_mem_arbiter_if.slave        bus,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_re,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_rdata
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [NUM_REQ-1:0] grant_q;
    logic [NUM_REQ-1:0] grant_next;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_next;
    logic [NUM_REQ-1:0] rd_valid_q;
    logic [NUM_REQ-1:0] rd_valid_next;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   after_owner;
    logic [NUM_REQ-1:0] cand;
    logic               own_req;
    logic               own_last;
    logic               own_re_raw;
    logic               own_we;
    logic               own_re;
    logic               natural_rel;
    logic               expire;
    logic               release_c;

    // First set bit of mask at or after start, wrapping; one-hot result.
    function automatic logic [NUM_REQ-1:0] pick(input logic [NUM_REQ-1:0] mask,
                                                input logic [PTR_W-1:0]   start);
        logic [NUM_REQ-1:0] hit;
        logic               found;
        int unsigned        idx;
        hit   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(start) + k) % NUM_REQ;
            if (!found && mask[PTR_W'(idx)]) begin
                hit[PTR_W'(idx)] = 1'b1;
                found            = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        owner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) owner = PTR_W'(i);
        end
    end

    assign after_owner = (32'(owner) == NUM_REQ - 1) ? '0 : owner + PTR_W'(1);

    // Owner's view of the bus; all terms are zero while nobody holds the grant.
    assign own_req    = |(grant_q & bus.req);
    assign own_last   = |(grant_q & bus.last);
    assign own_re_raw = |(grant_q & bus.re);
    assign own_we     = |(grant_q & bus.we);
    assign own_re     = own_re_raw & ~own_we;

    assign mem_we = own_we;
    assign mem_re = own_re;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                mem_addr  = bus.addr[i*ADDR_W +: ADDR_W];
                mem_wdata = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign natural_rel = (state == BUSY) & ((own_last & (own_re_raw | own_we)) | ~own_req);
    assign release_c   = natural_rel | expire;
    // The releasing owner may still hold req this cycle; it must not win the handover.
    assign cand        = bus.req & ~grant_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant_q;
        ptr_next      = ptr_q;
        rd_valid_next = own_re ? grant_q : '0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    grant_next = pick(bus.req, ptr_q);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (release_c) begin
                    ptr_next = after_owner;
                    if (|cand) begin
                        grant_next = pick(cand, after_owner);
                    end else begin
                        grant_next = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q    <= '0;
            ptr_q      <= '0;
            rd_valid_q <= '0;
        end else begin
            grant_q    <= grant_next;
            ptr_q      <= ptr_next;
            rd_valid_q <= rd_valid_next;
        end
    end

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [CNT_W-1:0] burst_cnt;
    logic             err_q;

    // Forced release only when the owner did not end the burst itself this cycle.
    assign expire = (state == BUSY) && (burst_cnt == CNT_W'(MAX_BURST - 1)) && !natural_rel;

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= expire;
            if ((state != BUSY) || release_c) burst_cnt <= '0;
            else                              burst_cnt <= burst_cnt + CNT_W'(1);
        end
    end

    assign bus.err = err_q;
`else
    assign expire  = 1'b0;
    assign bus.err = 1'b0;
`endif

    assign bus.grant    = grant_q;
    assign bus.busy     = |grant_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = mem_rdata;
endmodule

// File: tb/tb_slice_mem_arbiter.sv
// Bench for slice_mem_arbiter: directed steps plus a random phase, all checked each cycle
// against a requester-level arbitration model and a shadow copy of the slice memory.
module tb_slice_mem_arbiter;
    localparam int unsigned N  = 6;
    localparam int unsigned AW = 6;
    localparam int unsigned DW = 25;
    localparam int unsigned PW = 3;
`ifdef ARB_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem [64];
    int            n_we = 0;

    always #5 clk = ~clk;

    slice_mem_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    slice_mem_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)
`ifdef ARB_WATCHDOG_EN
        , .MAX_BURST(WD)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Single-port memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) if (mem_we === 1'b1) n_we++;

    logic [N-1:0]  d_req, d_last, d_re, d_we;
    logic [AW-1:0] d_addr [N];
    logic [DW-1:0] d_wdata [N];

    int            m_owner, m_ptr, m_rdv, m_cnt, m_released;
    logic          m_err;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] shadow [64];
    int            n_checks, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        if (i >= 0) v[PW'(i)] = 1'b1;
        return v;
    endfunction

    function automatic int first_from(input logic [N-1:0] m, input int p);
        for (int k = 0; k < int'(N); k++) begin
            if (m[PW'((p + k) % int'(N))]) return (p + k) % int'(N);
        end
        return -1;
    endfunction

    task automatic apply();
        bus.req  = d_req;
        bus.last = d_last;
        bus.re   = d_re;
        bus.we   = d_we;
        for (int i = 0; i < int'(N); i++) begin
            bus.addr[i*AW +: AW]  = d_addr[PW'(i)];
            bus.wdata[i*DW +: DW] = d_wdata[PW'(i)];
        end
    endtask

    task automatic idle_inputs();
        d_req = '0; d_last = '0; d_re = '0; d_we = '0;
        for (int i = 0; i < int'(N); i++) begin
            d_addr[PW'(i)]  = '0;
            d_wdata[PW'(i)] = '0;
        end
    endtask

    // One clock: drive, check at negedge, advance the model, return at posedge+1.
    task automatic tick(input string tag);
        int            o, nrdv;
        logic          ewe, ere, nat, frc;
        logic [N-1:0]  cand;
        logic [DW-1:0] nrdata;
        apply();
        @(negedge clk);
        o   = m_owner;
        ewe = 1'b0;
        ere = 1'b0;
        if (o >= 0) begin
            ewe = d_we[PW'(o)];
            ere = d_re[PW'(o)] & ~d_we[PW'(o)];
        end
        chk({tag, " grant"}, 32'(bus.grant), 32'(onehot(o)));
        chk({tag, " busy"}, 32'(bus.busy), 32'(o >= 0));
        chk({tag, " mem_we"}, 32'(mem_we), 32'(ewe));
        chk({tag, " mem_re"}, 32'(mem_re), 32'(ere));
        if (ewe || ere) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(d_addr[PW'(o)]));
        if (ewe) chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(d_wdata[PW'(o)]));
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(onehot(m_rdv)));
        if (m_rdv >= 0) chk({tag, " rd_data"}, 32'(bus.rd_data), 32'(m_rdata));
        chk({tag, " err"}, 32'(bus.err), 32'(m_err));

        nrdv   = -1;
        nrdata = '0;
        if (ewe) shadow[d_addr[PW'(o)]] = d_wdata[PW'(o)];
        if (ere) begin
            nrdv   = o;
            nrdata = shadow[d_addr[PW'(o)]];
        end
        m_released = -1;
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_rdv = -1; m_cnt = 0; m_err = 1'b0;
        end else begin
            m_rdv   = nrdv;
            m_rdata = nrdata;
            m_err   = 1'b0;
            if (o < 0) begin
                if (d_req != '0) m_owner = first_from(d_req, m_ptr);
                m_cnt = 0;
            end else begin
                nat = (d_last[PW'(o)] & (d_re[PW'(o)] | d_we[PW'(o)])) | ~d_req[PW'(o)];
                frc = (WD != 0) && !nat && (m_cnt == WD - 1);
                if (nat || frc) begin
                    m_ptr = (o + 1) % int'(N);
                    cand  = d_req;
                    cand[PW'(o)] = 1'b0;
                    m_owner    = (cand != '0) ? first_from(cand, m_ptr) : -1;
                    m_cnt      = 0;
                    m_released = o;
                end else begin
                    m_cnt++;
                end
                m_err = frc;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Current owner performs len accesses in the upper half of memory, then drops its request.
    task automatic run_burst(input string tag, input int len, input bit rd);
        int o;
        o = m_owner;
        for (int k = 0; k < len; k++) begin
            d_re[PW'(o)]    = rd;
            d_we[PW'(o)]    = ~rd;
            d_addr[PW'(o)]  = AW'(32 + $urandom_range(0, 31));
            d_wdata[PW'(o)] = DW'($urandom);
            d_last[PW'(o)]  = (k == len - 1);
            tick(tag);
        end
        d_re[PW'(o)] = 1'b0; d_we[PW'(o)] = 1'b0; d_last[PW'(o)] = 1'b0; d_req[PW'(o)] = 1'b0;
    endtask

    initial begin
        int o, we0;
        n_checks = 0; n_err = 0;
        m_owner = -1; m_ptr = 0; m_rdv = -1; m_cnt = 0; m_err = 1'b0;
        m_rdata = '0; m_released = -1;
        idle_inputs();
        rst = 1'b1;
        apply();
        @(posedge clk);
        #1;
        tick("reset");
        tick("reset");
        rst = 1'b0;

        // Host fills all 64 slices in one burst.
        d_req = 6'b000001;
        tick("t1_req");
        chk("t1_grant_latency", 32'(bus.grant), 32'(6'b000001));
        we0 = n_we;
        for (int a = 0; a < 64; a++) begin
            d_we[0]    = 1'b1;
            d_addr[0]  = AW'(a);
            d_wdata[0] = (a == 5) ? 25'h1ABCDE : DW'($urandom);
            d_last[0]  = (a == 63);
            tick("t1_wr");
        end
        idle_inputs();
        chk("t1_we_count", 32'(n_we - we0), 32'd64);
        chk("t1_release_grant", 32'(bus.grant), 32'd0);
        chk("t1_release_busy", 32'(bus.busy), 32'd0);

        // Simultaneous requests from a reset pointer, back-to-back handover.
        rst = 1'b1;
        tick("t2_rst");
        rst = 1'b0;
        d_req = 6'b100110;
        tick("t2_req");
        chk("t2_first", 32'(bus.grant), 32'(6'b000010));
        run_burst("t2_b1", 2, 1'b0);
        chk("t2_second", 32'(bus.grant), 32'(6'b000100));
        run_burst("t2_b2", 3, 1'b0);
        chk("t2_third", 32'(bus.grant), 32'(6'b100000));
        run_burst("t2_b3", 1, 1'b0);
        chk("t2_idle", 32'(bus.busy), 32'd0);

        // Read latency and routing.
        d_req = 6'b001000;
        tick("t3_req");
        d_re[3] = 1'b1; d_addr[3] = AW'(5);
        tick("t3_rd5");
        chk("t3_rd_valid", 32'(bus.rd_valid), 32'(6'b001000));
        chk("t3_rd_data", 32'(bus.rd_data), 32'(25'h1ABCDE));
        d_addr[3] = AW'(6); d_last[3] = 1'b1;
        tick("t3_rd6");
        idle_inputs();

        // Non-owner write strobes are ignored.
        d_req = 6'b000100;
        tick("t4_req");
        for (int k = 0; k < 4; k++) begin
            d_we[2] = 1'b1; d_addr[2] = AW'(40 + k); d_wdata[2] = DW'($urandom);
            d_last[2] = (k == 3);
            d_we[4] = 1'b1; d_addr[4] = AW'(20); d_wdata[4] = DW'($urandom);
            tick("t4_wr");
        end
        idle_inputs();
        tick("t4_gap");
        chk("t4_mem20_array", 32'(mem[20]), 32'(shadow[20]));
        d_req = 6'b000100;
        tick("t4_req2");
        d_re[2] = 1'b1; d_addr[2] = AW'(20); d_last[2] = 1'b1;
        tick("t4_rd20");
        chk("t4_rd20_data", 32'(bus.rd_data), 32'(shadow[20]));
        idle_inputs();

        // Reset with a read in flight.
        d_req = 6'b000010;
        tick("t5_req");
        d_re[1] = 1'b1; d_addr[1] = AW'(6);
        tick("t5_rd");
        d_addr[1] = AW'(7);
        rst = 1'b1;
        tick("t5_rst");
        chk("t5_grant", 32'(bus.grant), 32'd0);
        chk("t5_rd_valid", 32'(bus.rd_valid), 32'd0);
        rst = 1'b0;
        idle_inputs();
        d_req = 6'b100001;
        tick("t5_req2");
        chk("t5_ptr_zero", 32'(bus.grant), 32'(6'b000001));
        run_burst("t5_b0", 1, 1'b1);
        chk("t5_next", 32'(bus.grant), 32'(6'b100000));
        run_burst("t5_b5", 2, 1'b1);

        // Owner holds its request without ever signalling last.
        rst = 1'b1;
        tick("t6_rst");
        rst = 1'b0;
        idle_inputs();
        d_req = 6'b000011;
        tick("t6_req");
`ifdef ARB_WATCHDOG_EN
        for (int k = 0; k < WD; k++) tick("t6_hold");
        chk("t6_forced_handover", 32'(bus.grant), 32'(6'b000010));
        chk("t6_err_pulse", 32'(bus.err), 32'd1);
        tick("t6_after");
        chk("t6_err_clear", 32'(bus.err), 32'd0);
`else
        for (int k = 0; k < 110; k++) tick("t6_hold");
        chk("t6_still_held", 32'(bus.grant), 32'(6'b000001));
        chk("t6_no_err", 32'(bus.err), 32'd0);
`endif
        idle_inputs();
        tick("t6_drop");
        tick("t6_drop");

        // Random requests, strobes from owners and non-owners, random releases.
        for (int c = 0; c < 400; c++) begin
            o = m_owner;
            if ($urandom_range(0, 2) == 0) d_req[PW'($urandom_range(0, N - 1))] = 1'b1;
            for (int i = 0; i < int'(N); i++) begin
                d_re[PW'(i)]    = ($urandom_range(0, 2) == 0);
                d_we[PW'(i)]    = ($urandom_range(0, 2) == 0);
                d_last[PW'(i)]  = ($urandom_range(0, 3) == 0);
                d_addr[PW'(i)]  = AW'($urandom);
                d_wdata[PW'(i)] = DW'($urandom);
            end
            if (o >= 0 && $urandom_range(0, 15) == 0) d_req[PW'(o)] = 1'b0;
            tick("rand");
            if (m_released >= 0) d_req[PW'(m_released)] = 1'b0;
        end
        idle_inputs();
        tick("drain");
        tick("drain");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
